// File: rtl/mem_access_unit.sv
// RV32I memory stage: takes the ALU result as an address or pass-through value,
// runs one load/store at a time over req/gnt/rvalid and hands the result to writeback.
module mem_access_unit #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DWIDTH-1:0] alu_res_i,
    input  logic [DWIDTH-1:0] store_data_i,
    input  logic [2:0]        funct3_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [4:0]        rd_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DWIDTH-1:0] wb_data_o,
    output logic [4:0]        rd_o,
    output logic              err_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] WAIT_R = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic [DWIDTH-1:0] wb_q, wb_d;
    logic              err_q, err_d;

    logic [1:0]        off;
    logic              accErr;
    logic [3:0]        storeBe;
    logic [DWIDTH-1:0] storeWdata;
    logic [7:0]        byteSel;
    logic [15:0]       halfSel;
    logic [DWIDTH-1:0] loadVal;

    assign off = alu_res_i[1:0];

    // Illegal width/control and misalignment are decided at accept time.
    always_comb begin
        accErr = 1'b0;
        if (is_load_i && is_store_i) begin
            accErr = 1'b1;
        end else if (is_load_i) begin
            case (funct3_i)
                3'b000, 3'b100: accErr = 1'b0;
                3'b001, 3'b101: accErr = off[0];
                3'b010:         accErr = |off;
                default:        accErr = 1'b1;
            endcase
        end else if (is_store_i) begin
            case (funct3_i)
                3'b000:  accErr = 1'b0;
                3'b001:  accErr = off[0];
                3'b010:  accErr = |off;
                default: accErr = 1'b1;
            endcase
        end
    end

    always_comb begin
        storeBe    = 4'b1111;
        storeWdata = '0;
        if (is_store_i) begin
            storeWdata = store_data_i;
            case (funct3_i[1:0])
                2'b00: begin
                    storeBe    = 4'b0001 << off;
                    storeWdata = {4{store_data_i[7:0]}};
                end
                2'b01: begin
                    storeBe    = off[1] ? 4'b1100 : 4'b0011;
                    storeWdata = {2{store_data_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        byteSel = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        halfSel = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (f3_q)
            3'b000:  loadVal = {{(DWIDTH-8){byteSel[7]}}, byteSel};
            3'b100:  loadVal = {{(DWIDTH-8){1'b0}}, byteSel};
            3'b001:  loadVal = {{(DWIDTH-16){halfSel[15]}}, halfSel};
            3'b101:  loadVal = {{(DWIDTH-16){1'b0}}, halfSel};
            default: loadVal = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        wb_d    = wb_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    addr_d  = alu_res_i[AWIDTH-1:0];
                    be_d    = storeBe;
                    wdata_d = storeWdata;
                    we_d    = is_store_i;
                    f3_d    = funct3_i;
                    rd_d    = rd_i;
                    err_d   = accErr;
                    if (accErr) begin
                        wb_d    = '0;
                        state_d = DONE;
                    end else if (is_load_i || is_store_i) begin
                        wb_d    = '0;
                        state_d = REQ;
                    end else begin
                        wb_d    = alu_res_i;
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_d = we_q ? DONE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (mem_rvalid_i) begin
                    wb_d    = loadVal;
                    state_d = DONE;
                end
            end
            default: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            rd_q    <= '0;
            wb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            wb_q    <= wb_d;
            err_q   <= err_d;
        end
    end

    // Write enable is only meaningful while a request is outstanding.
    assign ready_o     = (state_q == IDLE);
    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = (state_q == REQ) && we_q;
    assign mem_addr_o  = {addr_q[AWIDTH-1:2], 2'b00};
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign valid_o     = (state_q == DONE);
    assign wb_data_o   = wb_q;
    assign rd_o        = rd_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized ops
// compared against a behavioural model of RV32I load/store semantics.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, ready_o;
    logic [31:0] alu_res_i, store_data_i;
    logic [2:0]  funct3_i;
    logic        is_load_i, is_store_i;
    logic [4:0]  rd_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        valid_o, ready_i;
    logic [31:0] wb_data_o;
    logic [4:0]  rd_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .valid_i(valid_i), .ready_o(ready_o),
        .alu_res_i(alu_res_i), .store_data_i(store_data_i), .funct3_i(funct3_i),
        .is_load_i(is_load_i), .is_store_i(is_store_i), .rd_i(rd_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .wb_data_o(wb_data_o), .rd_o(rd_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic        memOp;
        logic [31:0] wb;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic [31:0] wb;
        logic        err;
        logic [4:0]  rd;
        int          latency;
        int          reqCycles;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        bit          reqStable;
        bit          doneStable;
        bit          busyReadyLow;
        logic        postValid;
        logic        postReady;
        bit          timeout;
    } obs_t;

    // Architectural model: access size from funct3, alignment by modulo, lanes by shifting.
    function automatic exp_t refModel(bit ld, bit st, logic [2:0] f3, logic [31:0] a,
                                      logic [31:0] sd, logic [31:0] rdata);
        exp_t e;
        int size, off;
        logic [31:0] mask, v;
        e = '{default: 0};
        off  = int'(a[1:0]);
        size = 1 << f3[1:0];
        if (ld && st) e.err = 1'b1;
        else if (ld) e.err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (off % size != 0);
        else if (st) e.err = (f3 > 3'd2) || (off % size != 0);
        e.memOp = (ld || st) && !e.err;
        if (e.err || st) begin
            e.wb = 32'd0;
        end else if (!ld) begin
            e.wb = a;
        end else begin
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            v = (rdata >> (8 * off)) & mask;
            if (f3 < 3'd4 && size < 4) begin
                if (v[8*size-1]) v = v | ~mask;
            end
            e.wb = v;
        end
        e.be = 4'hF;
        if (st && !e.err) begin
            e.be = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
        end
        return e;
    endfunction

    // Drives one instruction from IDLE to handshake, acting as memory and writeback stage.
    task automatic applyStimulus(input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [4:0] rd, input logic [31:0] rdata,
                                 input int gntWait, input int rvalidWait, input int readyWait,
                                 output obs_t o);
        int cyc, gntAt, doneCnt;
        bit finished;
        o = '{default: 0};
        o.reqStable = 1; o.doneStable = 1; o.busyReadyLow = 1; o.latency = -1;
        valid_i = 1'b1; alu_res_i = a; store_data_i = sd; funct3_i = f3;
        is_load_i = ld; is_store_i = st; rd_i = rd;
        @(negedge clk);
        valid_i = 1'b0; alu_res_i = $urandom; store_data_i = $urandom; rd_i = 5'($urandom);
        cyc = 1; gntAt = -1; doneCnt = 0; finished = 0;
        while (!finished && cyc < 100) begin
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; ready_i = 1'b0; mem_rdata_i = $urandom;
            if (ready_o !== 1'b0) o.busyReadyLow = 0;
            if (mem_req_o === 1'b1) begin
                o.reqCycles++;
                if (o.reqCycles == 1) begin
                    o.addr = mem_addr_o; o.be = mem_be_o; o.wdata = mem_wdata_o; o.we = mem_we_o;
                end else if (mem_addr_o !== o.addr || mem_be_o !== o.be ||
                             mem_wdata_o !== o.wdata || mem_we_o !== o.we) begin
                    o.reqStable = 0;
                end
                if (o.reqCycles > gntWait) begin
                    mem_gnt_i = 1'b1;
                    gntAt = cyc;
                end
            end
            if (ld && gntAt >= 0 && cyc == gntAt + 1 + rvalidWait) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i = rdata;
            end
            if (valid_o === 1'b1) begin
                doneCnt++;
                if (doneCnt == 1) begin
                    o.latency = cyc; o.wb = wb_data_o; o.err = err_o; o.rd = rd_o;
                end else if (wb_data_o !== o.wb || err_o !== o.err || rd_o !== o.rd) begin
                    o.doneStable = 0;
                end
                if (doneCnt > readyWait) begin
                    ready_i = 1'b1;
                    finished = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (!finished) o.timeout = 1;
        ready_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        o.postValid = valid_o;
        o.postReady = ready_o;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0;
        alu_res_i = $urandom; rd_i = 5'd3; funct3_i = 3'b010;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; ready_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ready_o !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready_o);
        end
        checks++;
        if ({valid_o, mem_req_o, mem_we_o, err_o} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {valid_o, mem_req_o, mem_we_o, err_o});
        end
        checks++;
        if (mem_addr_o !== 32'd0 || mem_be_o !== 4'd0 || mem_wdata_o !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_membus: got addr %h be %b wdata %h expected zeros", mem_addr_o, mem_be_o, mem_wdata_o);
        end
        checks++;
        if (wb_data_o !== 32'd0 || rd_o !== 5'd0) begin
            errors++; $display("[TB] FAIL reset_wb: got wb %h rd %0d expected zeros", wb_data_o, rd_o);
        end
        valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        obs_t o;
        applyStimulus(0, 0, 3'b000, 32'h0000_1234, 32'hDEAD_BEEF, 5'd7, 32'd0, 0, 0, 0, o);
        checks++;
        if (o.timeout || o.latency != 1) begin
            errors++; $display("[TB] FAIL pass_latency: got %0d expected 1", o.latency);
        end
        checks++;
        if (o.wb !== 32'h0000_1234 || o.rd !== 5'd7 || o.err !== 1'b0) begin
            errors++; $display("[TB] FAIL pass_data: got wb %h rd %0d err %b expected 1234/7/0", o.wb, o.rd, o.err);
        end
        checks++;
        if (o.reqCycles != 0) begin
            errors++; $display("[TB] FAIL pass_noreq: got %0d req cycles expected 0", o.reqCycles);
        end
        checks++;
        if (o.postValid !== 1'b0 || o.postReady !== 1'b1) begin
            errors++; $display("[TB] FAIL pass_release: got valid %b ready %b expected 0/1", o.postValid, o.postReady);
        end
    endtask

    task automatic test_store_byte();
        obs_t o;
        applyStimulus(0, 1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 5'd0, 32'd0, 2, 0, 0, o);
        checks++;
        if (o.reqCycles != 3 || !o.reqStable) begin
            errors++; $display("[TB] FAIL sb_req: got %0d cycles stable %0d expected 3/1", o.reqCycles, o.reqStable);
        end
        checks++;
        if (o.addr !== 32'h0000_1000 || o.be !== 4'b1000 || o.wdata !== 32'hDDDD_DDDD || o.we !== 1'b1) begin
            errors++; $display("[TB] FAIL sb_bus: got %h %b %h we %b expected 00001000 1000 dddddddd 1", o.addr, o.be, o.wdata, o.we);
        end
        checks++;
        if (o.timeout || o.latency != 4 || o.err !== 1'b0 || o.wb !== 32'd0) begin
            errors++; $display("[TB] FAIL sb_done: got lat %0d err %b wb %h expected 4/0/0", o.latency, o.err, o.wb);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3Tab [3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] rdTab [3] = '{32'h0080_FF00, 32'h0080_FF00, 32'h8000_0000};
        logic [31:0] expTab[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000};
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, f3Tab[i], 32'h0000_2002, 32'd0, 5'd12, rdTab[i], 0, 0, 0, o);
            checks++;
            if (o.timeout || o.wb !== expTab[i] || o.err !== 1'b0 || o.latency != 3) begin
                errors++; $display("[TB] FAIL load_ext%0d: got wb %h err %b lat %0d expected %h/0/3", i, o.wb, o.err, o.latency, expTab[i]);
            end
            checks++;
            if (o.addr !== 32'h0000_2000 || o.be !== 4'hF || o.we !== 1'b0) begin
                errors++; $display("[TB] FAIL load_bus%0d: got %h %b we %b expected 00002000 1111 0", i, o.addr, o.be, o.we);
            end
        end
    endtask

    task automatic test_errors();
        obs_t o;
        applyStimulus(1, 0, 3'b010, 32'h0000_3001, 32'd0, 5'd4, 32'hFFFF_FFFF, 0, 0, 0, o);
        checks++;
        if (o.timeout || o.reqCycles != 0 || o.latency != 1 || o.err !== 1'b1 || o.wb !== 32'd0) begin
            errors++; $display("[TB] FAIL err_lw: got req %0d lat %0d err %b wb %h expected 0/1/1/0", o.reqCycles, o.latency, o.err, o.wb);
        end
        applyStimulus(0, 1, 3'b011, 32'h0000_4000, 32'h1234_5678, 5'd0, 32'd0, 0, 0, 0, o);
        checks++;
        if (o.timeout || o.reqCycles != 0 || o.latency != 1 || o.err !== 1'b1 || o.wb !== 32'd0) begin
            errors++; $display("[TB] FAIL err_st: got req %0d lat %0d err %b wb %h expected 0/1/1/0", o.reqCycles, o.latency, o.err, o.wb);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        valid_i = 1'b1; is_load_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'b000;
        alu_res_i = 32'hCAFE_0001; rd_i = 5'd5; ready_i = 1'b0;
        @(negedge clk);
        alu_res_i = 32'h0BAD_F00D; rd_i = 5'd9;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || wb_data_o !== 32'hCAFE_0001 || rd_o !== 5'd5) begin
                errors++; $display("[TB] FAIL bp_hold%0d: got v %b r %b wb %h rd %0d expected 1/0/cafe0001/5", i, valid_o, ready_o, wb_data_o, rd_o);
            end
            @(negedge clk);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_release: got valid %b ready %b expected 0/1", valid_o, ready_o);
        end
        @(negedge clk);
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || wb_data_o !== 32'h0BAD_F00D || rd_o !== 5'd9) begin
            errors++; $display("[TB] FAIL bp_next: got v %b wb %h rd %0d expected 1/0badf00d/9", valid_o, wb_data_o, rd_o);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        applyStimulus(1, 0, 3'b010, 32'h0000_6008, 32'd0, 5'd21, 32'h1357_9BDF, 1, 2, 4, o);
        checks++;
        if (o.timeout || !o.doneStable || !o.busyReadyLow || o.wb !== 32'h1357_9BDF || o.rd !== 5'd21) begin
            errors++; $display("[TB] FAIL bp_load: got stable %0d busy %0d wb %h rd %0d expected 1/1/13579bdf/21", o.doneStable, o.busyReadyLow, o.wb, o.rd);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit leak;
        valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010;
        alu_res_i = 32'h0000_5000; rd_i = 5'd2;
        @(negedge clk);
        valid_i = 1'b0; mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFEED_FACE;
        checks++;
        if (ready_o !== 1'b1 || mem_req_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid_idle: got ready %b req %b valid %b expected 1/0/0", ready_o, mem_req_o, valid_o);
        end
        leak = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            if (valid_o !== 1'b0 || ready_o !== 1'b1) leak = 1;
        end
        checks++;
        if (leak) begin
            errors++; $display("[TB] FAIL rstmid_late: got valid/busy after late rvalid expected idle");
        end
        applyStimulus(1, 0, 3'b001, 32'h0000_5002, 32'd0, 5'd2, 32'h7ABC_0000, 0, 1, 0, o);
        checks++;
        if (o.timeout || o.wb !== 32'h0000_7ABC || o.err !== 1'b0 || o.latency != 4) begin
            errors++; $display("[TB] FAIL rstmid_next: got wb %h err %b lat %0d expected 00007abc/0/4", o.wb, o.err, o.latency);
        end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        bit ld, st;
        logic [2:0] f3;
        logic [31:0] a, sd, rdata;
        int kind, gw, rw, yw, expLat, expReq;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            ld = (kind <= 3) || (kind == 9);
            st = (kind >= 4 && kind <= 6) || (kind == 9);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) f3 = st ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 1) * 4) + $urandom_range(0, 1));
            a = $urandom; sd = $urandom; rdata = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            gw = $urandom_range(0, 3); rw = $urandom_range(0, 3); yw = $urandom_range(0, 3);
            e = refModel(ld, st, f3, a, sd, rdata);
            applyStimulus(ld, st, f3, a, sd, 5'(n), rdata, gw, rw, yw, o);
            expLat = !e.memOp ? 1 : (st ? 2 + gw : 3 + gw + rw);
            expReq = e.memOp ? gw + 1 : 0;
            checks++;
            if (o.timeout || o.wb !== e.wb || o.err !== e.err || o.rd !== 5'(n)) begin
                errors++; $display("[TB] FAIL rnd%0d_result: got wb %h err %b rd %0d expected %h/%b/%0d", n, o.wb, o.err, o.rd, e.wb, e.err, n);
            end
            checks++;
            if (o.latency != expLat || o.reqCycles != expReq) begin
                errors++; $display("[TB] FAIL rnd%0d_timing: got lat %0d req %0d expected %0d/%0d", n, o.latency, o.reqCycles, expLat, expReq);
            end
            checks++;
            if (!o.reqStable || !o.doneStable || !o.busyReadyLow || o.postValid !== 1'b0 || o.postReady !== 1'b1) begin
                errors++; $display("[TB] FAIL rnd%0d_handshake: got rs %0d ds %0d busy %0d pv %b pr %b expected 1/1/1/0/1", n, o.reqStable, o.doneStable, o.busyReadyLow, o.postValid, o.postReady);
            end
            if (e.memOp) begin
                checks++;
                if (o.addr !== {a[31:2], 2'b00} || o.be !== e.be || o.we !== st || (st && o.wdata !== e.wdata)) begin
                    errors++; $display("[TB] FAIL rnd%0d_bus: got %h %b %h we %b expected %h %b %h %b", n, o.addr, o.be, o.wdata, o.we, {a[31:2], 2'b00}, e.be, e.wdata, st);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; valid_i = 1'b0; alu_res_i = '0; store_data_i = '0; funct3_i = '0;
        is_load_i = 1'b0; is_store_i = 1'b0; rd_i = '0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rdata_i = '0; ready_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_passthrough();
        test_store_byte();
        test_load_extend();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory stage sitting directly downstream of the execute-stage ALU. It takes the ALU result as the effective address, or as a pass-through value for non-memory ops. It performs RV32I loads and stores over a request/grant/response data-memory interface and hands a writeback value to the writeback stage using a valid/ready handshake. The unit handles one instruction at a time and is controlled by an FSM.

Parameters:
DWIDTH, 32, data width (only 32 is supported)
AWIDTH, 32, address width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
valid_i  input  1  execute stage presents an instruction
ready_o  output  1  unit can accept; transfer when valid_i && ready_o
alu_res_i  input  DWIDTH  ALU result: effective address, or pass-through value
store_data_i  input  DWIDTH  rs2 data for stores
funct3_i  input  3  load/store width and sign selector
is_load_i  input  1  instruction is a load
is_store_i  input  1  instruction is a store
rd_i  input  5  destination register
mem_req_o  output  1  memory request
mem_we_o  output  1  1 = write
mem_addr_o  output  AWIDTH  word-aligned address ({alu_res[AWIDTH-1:2],2'b00})
mem_be_o  output  4  byte enables
mem_wdata_o  output  DWIDTH  lane-replicated store data
mem_gnt_i  input  1  request accepted this cycle
mem_rvalid_i  input  1  read data valid
mem_rdata_i  input  DWIDTH  read data word
valid_o  output  1  writeback value available
ready_i  input  1  writeback stage accepts
wb_data_o  output  DWIDTH  writeback value
rd_o  output  5  destination register
err_o  output  1  misaligned access or illegal funct3/control; qualified by valid_o

Behaviour:
- FSM states: IDLE, REQ, WAIT_R, DONE. ready_o = (state==IDLE).
- Reset: state=IDLE; mem_req_o, mem_we_o, valid_o and err_o are 0; mem_addr_o, mem_be_o, mem_wdata_o, wb_data_o and rd_o are 0.
- Accept in IDLE: register alu_res_i, store_data_i, funct3_i, rd_i and the op type.
  - Non-memory op: go to DONE with wb_data=alu_res_i.
  - Load or store: go to REQ.
  - Error: go to DONE with err_o=1, wb_data=0, and no memory request.
- Error conditions:
  - is_load_i && is_store_i.
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
- REQ:
  - mem_req_o=1. mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are held stable until mem_gnt_i.
  - On gnt, a store goes to DONE with wb_data=0, and a load goes to WAIT_R.
  - mem_req_o drops the cycle after gnt.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{byte}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata={2{half}}.
  - SW: be=4'b1111.
- Loads drive be=4'b1111 and we=0.
- WAIT_R: on mem_rvalid_i, capture and extract, then go to DONE.
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW is the full word.
  - rvalid in the same cycle as gnt is not allowed by the memory protocol; rvalid is sampled only in WAIT_R.
- DONE: valid_o=1, with wb_data_o, rd_o and err_o stable. On ready_i go to IDLE; valid_o=0 the next cycle. No combinational path from ready_i to valid_o.
- Latency (accept at edge N):
  - Non-memory op or error: valid_o from N+1.
  - Store with immediate gnt: req in N+1, valid_o at N+2.
  - Load with gnt at N+1 and rvalid at N+2: valid_o at N+3.
- Stalls: gnt held low keeps the unit in REQ indefinitely; ready_i held low keeps it in DONE. No input is accepted while busy.
- mem_rvalid_i or mem_gnt_i outside REQ/WAIT_R is ignored.
- Reset mid-operation returns to IDLE on that edge, dropping mem_req_o and valid_o. A late rvalid after reset is ignored.

Test Plan:
- Pass-through: alu_res=0x0000_1234, no mem op, ready_i=1 -> valid_o one cycle after accept, wb_data_o=0x1234, rd_o echoed, mem_req_o never asserted.
- SB at addr 0x1003, rs2=0xAABBCCDD, gnt after 2 wait cycles -> req held 3 cycles with stable mem_addr_o=0x1000, mem_be_o=1000, mem_wdata_o=0xDDDDDDDD, then valid_o with err_o=0.
- LB and LBU at 0x2002, rdata=0x0080FF00 -> wb_data_o=0xFFFFFF80 and 0x00000080 respectively. LH at 0x2002 with rdata=0x80000000 -> wb_data_o=0xFFFF8000.
- Misaligned LW at 0x3001, and store with funct3=011 -> no mem_req_o, valid_o next cycle, err_o=1, wb_data_o=0.
- Backpressure: ready_i low 4 cycles in DONE -> outputs stable and ready_o=0. A new valid_i is accepted only the cycle after the handshake.
- Reset asserted in WAIT_R, then rvalid arrives -> unit is IDLE, valid_o stays 0, and the next load completes normally.
